// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: latches IR, reads rs/rt from the register file, presents A/B over valid/ready.
// Also owns the RF write port (registered 1-cycle write pulse) and forwards that pulse into A/B.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_read_address_0,
    output logic [ADDR_W-1:0] rf_read_address_1,
    input  logic [DATA_W-1:0] rf_read_data_0,
    input  logic [DATA_W-1:0] rf_read_data_1,
    output logic [ADDR_W-1:0] rf_write_address_0,
    output logic              rf_write_en,
    output logic [DATA_W-1:0] rf_write_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t              state_q;
    logic [31:0]         ir_q;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                out_valid_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [ADDR_W-1:0]   rs, rt;
    logic                fwd_a, fwd_b;

    assign rs = ir_q[21 +: ADDR_W];
    assign rt = ir_q[16 +: ADDR_W];

    // A pending write pulse never targets r0, so a match alone implies a nonzero address.
    assign fwd_a = wr_en_q && (wr_addr_q == rs);
    assign fwd_b = wr_en_q && (wr_addr_q == rt);

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        case (state_q)
            S_READ: begin
                if (rs == '0)      a_d = '0;
                else if (fwd_a)    a_d = wr_data_q;
                else               a_d = rf_read_data_0;
                if (rt == '0)      b_d = '0;
                else if (fwd_b)    b_d = wr_data_q;
                else               b_d = rf_read_data_1;
            end
            S_VALID: begin
                if (fwd_a && rs != '0) a_d = wr_data_q;
                if (fwd_b && rt != '0) b_d = wr_data_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            // Writeback path runs independently of the operand FSM and is never stalled.
            wr_en_q <= wb_valid && (wb_addr != '0);
            if (wb_valid && (wb_addr != '0)) begin
                wr_addr_q <= wb_addr;
                wr_data_q <= wb_data;
            end
            a_q <= a_d;
            b_q <= b_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        ir_q    <= in_instr;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    state_q     <= S_VALID;
                    out_valid_q <= 1'b1;
                end
                S_VALID: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready           = (state_q == S_IDLE);
    assign out_valid          = out_valid_q;
    assign out_instr          = ir_q;
    assign out_a              = a_q;
    assign out_b              = b_q;
    assign rf_read_address_0  = rs;
    assign rf_read_address_1  = rt;
    assign rf_write_address_0 = wr_addr_q;
    assign rf_write_en        = wr_en_q;
    assign rf_write_data      = wr_data_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model plus an architectural-register reference
// (A/B while valid must equal the current value of rs/rt), directed cases then random traffic.
module tb_operand_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, out_instr, out_a, out_b;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rf_read_address_0, rf_read_address_1, rf_write_address_0;
    logic [31:0] rf_read_data_0, rf_read_data_1, rf_write_data;
    logic        rf_write_en;

    operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_a(out_a), .out_b(out_b),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_read_address_0(rf_read_address_0), .rf_read_address_1(rf_read_address_1),
        .rf_read_data_0(rf_read_data_0), .rf_read_data_1(rf_read_data_1),
        .rf_write_address_0(rf_write_address_0), .rf_write_en(rf_write_en),
        .rf_write_data(rf_write_data)
    );

    // Register file attached to the DUT; r0 deliberately holds a nonzero value.
    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'hDEADBEEF;
        if (i == 1) return 32'hA5A5A5A5;
        if (i == 2) return 32'h0;
        return (32'(i) * 32'h01010101) ^ 32'h13579BDF;
    endfunction

    logic [31:0] rf_mem [32];
    logic        rf_init;
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else if (rf_write_en) begin
            rf_mem[rf_write_address_0] <= rf_write_data;
        end
    end
    assign rf_read_data_0 = rf_mem[rf_read_address_0];
    assign rf_read_data_1 = rf_mem[rf_read_address_1];

    // Reference model state
    logic [31:0] arch [32];
    logic [31:0] m_ir;
    logic        m_idle, m_pend_v;
    logic [4:0]  m_pend_a;
    logic [31:0] m_pend_d;
    int          m_age;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] archv(input logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : arch[r];
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [4:0] rs, rt;
        rs = m_ir[25:21];
        rt = m_ir[20:16];
        chk("in_ready", 32'(in_ready), 32'(m_idle));
        chk("out_valid", 32'(out_valid), 32'(!m_idle && m_age >= 1));
        chk("wr_en", 32'(rf_write_en), 32'(m_pend_v));
        if (m_pend_v) begin
            chk("wr_addr", 32'(rf_write_address_0), 32'(m_pend_a));
            chk("wr_data", rf_write_data, m_pend_d);
        end
        if (!m_idle) begin
            chk("rd_addr0", 32'(rf_read_address_0), 32'(rs));
            chk("rd_addr1", 32'(rf_read_address_1), 32'(rt));
        end
        if (!m_idle && m_age >= 1) begin
            chk("out_instr", out_instr, m_ir);
            chk("out_a", out_a, archv(rs));
            chk("out_b", out_b, archv(rt));
        end
    endtask

    task automatic cyc(input logic r, input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic wv, input logic [4:0] wa, input logic [31:0] wd);
        rst       = r;
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        wb_valid  = wv;
        wb_addr   = wa;
        wb_data   = wd;
        @(posedge clk);
        // An in-flight pulse reaches the register file at this edge even if reset is asserted.
        if (m_pend_v) arch[m_pend_a] = m_pend_d;
        if (r) begin
            m_idle   = 1'b1;
            m_pend_v = 1'b0;
            m_age    = 0;
            m_ir     = 32'h0;
        end else begin
            m_pend_v = wv && (wa != 5'd0);
            m_pend_a = wa;
            m_pend_d = wd;
            if (m_idle) begin
                if (iv) begin
                    m_idle = 1'b0;
                    m_age  = 0;
                    m_ir   = ins;
                end
            end else if (m_age >= 1 && ordy) begin
                m_idle = 1'b1;
            end else begin
                m_age++;
            end
        end
        #1;
        check_all();
        if (r) begin
            chk("rst_a", out_a, 32'h0);
            chk("rst_b", out_b, 32'h0);
            chk("rst_ir", out_instr, 32'h0);
            chk("rst_waddr", 32'(rf_write_address_0), 32'h0);
            chk("rst_wdata", rf_write_data, 32'h0);
        end
    endtask

    task automatic idle_cyc(input logic ordy);
        cyc(1'b0, 1'b0, 32'h0, ordy, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ins;
        rf_init  = 1'b1;
        m_idle   = 1'b1;
        m_pend_v = 1'b0;
        m_pend_a = 5'd0;
        m_pend_d = 32'h0;
        m_age    = 0;
        m_ir     = 32'h0;
        for (int i = 0; i < 32; i++) arch[i] = init_val(i);

        // Reset and register-file preload
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        rf_init = 1'b0;

        // Basic read: rs=1, rt=2; valid is seen by the ALU two edges after accept
        cyc(1'b0, 1'b1, mk(5'd1, 5'd2, 5'd9), 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t1_not_yet_valid", 32'(out_valid), 32'h0);
        idle_cyc(1'b0);
        chk("t1_a", out_a, 32'hA5A5A5A5);
        chk("t1_b", out_b, 32'h0);
        idle_cyc(1'b1);

        // Write pulse during READ is forwarded into both operands
        cyc(1'b0, 1'b1, mk(5'd3, 5'd3, 5'd0), 1'b0, 1'b1, 5'd3, 32'h5A5A5A5A);
        idle_cyc(1'b0);
        chk("t2_a", out_a, 32'h5A5A5A5A);
        chk("t2_b", out_b, 32'h5A5A5A5A);
        idle_cyc(1'b1);

        // Write pulse while stalled in VALID updates the held operand
        cyc(1'b0, 1'b1, mk(5'd1, 5'd2, 5'd0), 1'b0, 1'b0, 5'd0, 32'h0);
        idle_cyc(1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd1, 32'h12345678);
        idle_cyc(1'b0);
        chk("t3_a", out_a, 32'h12345678);
        chk("t3_b", out_b, 32'h0);
        chk("t3_ir", out_instr, mk(5'd1, 5'd2, 5'd0));
        idle_cyc(1'b1);
        chk("t3_idle", 32'(in_ready), 32'h1);

        // r0 reads as zero and writes to r0 are dropped
        cyc(1'b0, 1'b1, mk(5'd0, 5'd1, 5'd0), 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
        chk("t4_no_pulse", 32'(rf_write_en), 32'h0);
        idle_cyc(1'b0);
        chk("t4_a", out_a, 32'h0);
        idle_cyc(1'b1);

        // in_valid held high: only one accepted until the output handshake
        cyc(1'b0, 1'b1, mk(5'd4, 5'd5, 5'd0), 1'b0, 1'b0, 5'd0, 32'h0);
        cyc(1'b0, 1'b1, mk(5'd6, 5'd7, 5'd0), 1'b0, 1'b0, 5'd0, 32'h0);
        cyc(1'b0, 1'b1, mk(5'd6, 5'd7, 5'd0), 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t5_first", out_instr, mk(5'd4, 5'd5, 5'd0));
        cyc(1'b0, 1'b1, mk(5'd6, 5'd7, 5'd0), 1'b1, 1'b0, 5'd0, 32'h0);
        chk("t5_ready_after_hs", 32'(in_ready), 32'h1);
        cyc(1'b0, 1'b1, mk(5'd6, 5'd7, 5'd0), 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t5_accepted", 32'(in_ready), 32'h0);
        idle_cyc(1'b0);
        chk("t5_second", out_instr, mk(5'd6, 5'd7, 5'd0));
        idle_cyc(1'b1);

        // Reset in VALID with a write pending
        cyc(1'b0, 1'b1, mk(5'd5, 5'd6, 5'd0), 1'b0, 1'b0, 5'd0, 32'h0);
        idle_cyc(1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd5, 32'hCAFEF00D);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'd6, 32'hBADC0DE5);
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_wr_en", 32'(rf_write_en), 32'h0);
        chk("t6_ready", 32'(in_ready), 32'h1);

        // Random traffic on a small register window to provoke forwarding hits
        for (int n = 0; n < 400; n++) begin
            ins        = $urandom;
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            cyc(1'b0, 1'($urandom_range(0, 1)), ins, 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
